ci_issuer: RTL and testbench

Initiator side of the multicycle floating-point custom-instruction interface (clk_en/start/dataa/datab/result/done) used by our mul_add-style units. It accepts operand pairs over a valid/ready stream, drives one custom-instruction transaction at a time, waits for done, and returns the result on a valid/ready output stream. It sits between a hardware sequencer or test driver and any CI datapath (mul_add, CORDIC stages).

---
 rtl/ci_issuer.sv | 127 ++++++++++++
 tb/tb_ci_issuer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ci_issuer.sv
// Initiator for the multicycle custom-instruction interface: valid/ready operand in, one CI transaction, valid/ready result out.
// Optional done-timeout watchdog enabled by defining CI_TIMEOUT_EN.
module ci_issuer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dataa,
  input  logic [DATA_W-1:0] in_datab,
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic [DATA_W-1:0] ci_result,
  input  logic              ci_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                terr_q, terr_d;
  logic                timeout;
  logic                active;

  assign active = (state_q == S_ISSUE) || (state_q == S_WAIT);

`ifdef CI_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  // A done on the limit cycle takes priority over the timeout.
  assign timeout = active && !ci_done && (tcnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == S_IDLE && in_valid) tcnt_d = '0;
    else if (active)                   tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) tcnt_q <= '0;
    else         tcnt_q <= tcnt_d;
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)            state_d = S_ISSUE;
      S_ISSUE: state_d = (ci_done || timeout) ? S_HOLD : S_WAIT;
      S_WAIT:  if (ci_done || timeout)  state_d = S_HOLD;
      S_HOLD:  if (out_ready)           state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = aclr_n && (state_q == S_IDLE);
    ci_start  = (state_q == S_ISSUE);
    ci_clk_en = active;
    out_valid = (state_q == S_HOLD);
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    terr_d = terr_q;
    if (state_q == S_IDLE && in_valid) begin
      a_d = in_dataa;
      b_d = in_datab;
    end
    if (active && ci_done) begin
      res_d = ci_result;
    end else if (timeout) begin
      res_d  = DATA_W'(32'h7FC0_0000);
      terr_d = 1'b1;
    end
    if (state_q == S_HOLD && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign ci_dataa    = a_q;
  assign ci_datab    = b_q;
  assign out_result  = res_q;
  assign op_count    = cnt_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ci_issuer.sv
// Directed + randomized bench for ci_issuer with a transaction-level CI and handshake model.
module tb_ci_issuer;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned T  = 8;
`ifdef CI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic aclr_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, ci_done = 1'b0;
  logic [DW-1:0] in_dataa = '0, in_datab = '0, ci_result = '0;
  logic in_ready, ci_clk_en, ci_start, out_valid, busy, timeout_err;
  logic [DW-1:0] ci_dataa, ci_datab, out_result;
  logic [CW-1:0] op_count;

  int unsigned tests = 0, fails = 0, starts = 0;
  int unsigned exp_cnt = 0;
  logic exp_terr = 1'b0;

  ci_issuer #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dataa(in_dataa), .in_datab(in_datab), .ci_clk_en(ci_clk_en),
    .ci_start(ci_start), .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_result(ci_result), .ci_done(ci_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .busy(busy),
    .op_count(op_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ci_start === 1'b1) starts++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: CI answers lat cycles after start (0 = with start); consumer stalls `stall` cycles.
  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] r,
                       input int unsigned lat, input int unsigned stall);
    int unsigned s0, nw;
    logic to;
    logic [DW-1:0] exp_res;
    to = TO_EN && (lat >= T);
    nw = to ? T - 1 : lat;
    exp_res = to ? 32'h7FC0_0000 : r;
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
    s0 = starts;
    in_valid = 1'b1; in_dataa = a; in_datab = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_dataa = $urandom; in_datab = $urandom;
    check("issue_start", ci_start, 1);
    check("issue_clk_en", ci_clk_en, 1);
    check("issue_dataa", ci_dataa, a);
    check("issue_datab", ci_datab, b);
    check("issue_in_ready", in_ready, 0);
    check("issue_busy", busy, 1);
    for (int k = 0; k < int'(nw); k++) begin
      @(posedge clk); #1;
      check("wait_start", ci_start, 0);
      check("wait_clk_en", ci_clk_en, 1);
      check("wait_dataa", ci_dataa, a);
      check("wait_datab", ci_datab, b);
      check("wait_out_valid", out_valid, 0);
    end
    if (!to) begin ci_done = 1'b1; ci_result = r; end
    @(posedge clk); #1;
    ci_done = 1'b0; ci_result = $urandom;
    if (to) exp_terr = 1'b1;
    check("hold_out_valid", out_valid, 1);
    check("hold_result", out_result, exp_res);
    check("hold_clk_en", ci_clk_en, 0);
    check("hold_in_ready", in_ready, 0);
    check("hold_terr", timeout_err, exp_terr);
    check("one_start", starts, s0 + 1);
    for (int k = 0; k < int'(stall); k++) begin
      ci_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_result", out_result, exp_res);
      check("bp_start", ci_start, 0);
      check("bp_clk_en", ci_clk_en, 0);
      check("bp_in_ready", in_ready, 0);
    end
    ci_done = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    check("ret_out_valid", out_valid, 0);
    check("ret_in_ready", in_ready, 1);
    check("ret_op_count", op_count, exp_cnt);
    check("ret_dataa_held", ci_dataa, a);
    check("ret_starts", starts, s0 + 1);
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_start", ci_start, 0);
    check("rst_clk_en", ci_clk_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dataa", ci_dataa, 0);
    check("rst_datab", ci_datab, 0);
    check("rst_result", out_result, 0);
    check("rst_op_count", op_count, 0);
    check("rst_terr", timeout_err, 0);
    @(negedge clk); aclr_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'h3F0B_851F, 32'h40AA_60FE, 32'h4103_9E21, 3, 0);
    check("single_count", op_count, 1);
    do_op($urandom, $urandom, 32'h3F80_0000, 0, 0);
    do_op($urandom, $urandom, $urandom, 2, 10);
    for (int i = 0; i < 3; i++)
      do_op($urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 3));

    // Reset two cycles after start, while waiting for done
    in_valid = 1'b1; in_dataa = $urandom; in_datab = $urandom;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    aclr_n = 1'b0;
    #1;
    exp_cnt = 0; exp_terr = 1'b0;
    check("mid_rst_start", ci_start, 0);
    check("mid_rst_clk_en", ci_clk_en, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_dataa", ci_dataa, 0);
    @(negedge clk); aclr_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++)
      do_op($urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 2));
    check("wrap_count", op_count, 1);

`ifdef CI_TIMEOUT_EN
    aclr_n = 1'b0; #1;
    exp_cnt = 0; exp_terr = 1'b0;
    @(negedge clk); aclr_n = 1'b1;
    @(posedge clk); #1;
    do_op($urandom, $urandom, 32'h4049_0FDB, T - 1, 1);
    check("limit_done_terr", timeout_err, 0);
    do_op($urandom, $urandom, $urandom, T + 5, 2);
    check("timeout_terr", timeout_err, 1);
    do_op($urandom, $urandom, $urandom, 1, 0);
    check("sticky_terr", timeout_err, 1);
    check("timeout_count", op_count, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
